// File: rtl/sign_extend.sv
// Immediate-extension unit: widens an IN_W immediate to OUT_W using one of four
// fixed extension modes, with an optional registered copy and load-valid flag.
module sign_extend #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  a,
  input  logic             en,
  output logic [OUT_W-1:0] y,
  output logic [OUT_W-1:0] y_r,
  output logic             y_r_valid
);

  // Width casts are used instead of replications so IN_W == OUT_W needs no special case.
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  assign sext = OUT_W'(signed'(a));
  assign zext = OUT_W'(a);

  generate
    if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
      $error("sign_extend: IN_W must satisfy 1 <= IN_W <= OUT_W");
    end

    if (MODE == 0) begin : g_sext
      assign y = sext;
    end else if (MODE == 1) begin : g_zext
      assign y = zext;
    end else if (MODE == 2) begin : g_upper
      if (OUT_W < 2 * IN_W) begin : g_bad_upper
        $error("sign_extend: MODE 2 requires OUT_W >= 2*IN_W");
      end
      assign y = zext << (OUT_W - IN_W);
    end else if (MODE == 3) begin : g_branch
      // Bits shifted past the top are dropped by the fixed OUT_W width.
      assign y = sext << 2;
    end else begin : g_bad_mode
      $error("sign_extend: unsupported MODE");
      assign y = '0;
    end
  endgenerate

  logic [OUT_W-1:0] y_r_q;
  logic [OUT_W-1:0] y_r_d;
  logic             valid_q;
  logic             valid_d;

  always_comb begin
    y_r_d   = y_r_q;
    valid_d = valid_q;
    if (en) begin
      y_r_d   = y;
      valid_d = 1'b1;
    end
  end

  // Active-low synchronous reset wins over en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      y_r_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      y_r_q   <= y_r_d;
      valid_q <= valid_d;
    end
  end

  assign y_r       = y_r_q;
  assign y_r_valid = valid_q;

endmodule

// File: tb/tb_sign_extend.sv
// Directed bench for sign_extend: one instance per extension mode sharing stimulus,
// combinational checks on the falling edge and registered-path checks after loads.
module tb_sign_extend;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] a;

  logic [31:0] y0, y1, y2, y3;
  logic [31:0] yr0, yr1, yr2, yr3;
  logic        v0, v1, v2, v3;

  int total = 0;
  int bad   = 0;

  sign_extend #(.IN_W(16), .OUT_W(32), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(y0), .y_r(yr0), .y_r_valid(v0));
  sign_extend #(.IN_W(16), .OUT_W(32), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(y1), .y_r(yr1), .y_r_valid(v1));
  sign_extend #(.IN_W(16), .OUT_W(32), .MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(y2), .y_r(yr2), .y_r_valid(v2));
  sign_extend #(.IN_W(16), .OUT_W(32), .MODE(3)) u_m3 (
    .clk(clk), .rst(rst), .a(a), .en(en), .y(y3), .y_r(yr3), .y_r_valid(v3));

  initial clk = 1'b0;
  always #7 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] sweep_a [16] = '{
    16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h8001, 16'h4000,
    16'hC000, 16'h00FF, 16'hFF00, 16'h7FFE, 16'h8FFF, 16'h5555, 16'hAAAA, 16'h0080};
  logic [31:0] sweep_y [16] = '{
    32'h00000000, 32'h00000001, 32'h00007FFF, 32'hFFFF8000,
    32'hFFFFFFFF, 32'h00001234, 32'hFFFF8001, 32'h00004000,
    32'hFFFFC000, 32'h000000FF, 32'hFFFFFF00, 32'h00007FFE,
    32'hFFFF8FFF, 32'h00005555, 32'hFFFFAAAA, 32'h00000080};

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    a   = 16'h1234;

    // Reset held for two edges
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_y_r", yr0, 32'h0);
    check("rst_valid", {31'b0, v0}, 32'h0);
    check("rst_no_effect_y", y0, 32'h00001234);

    // MODE 0 sweep: drive on rising edge, check on falling edge
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      a = sweep_a[i];
      @(negedge clk);
      check($sformatf("m0_sweep_%0d", i), y0, sweep_y[i]);
      $display("sweep %0d: a=%h y=%h", i, a, y0);
    end

    // Other modes
    @(posedge clk); a = 16'h8001; @(negedge clk);
    check("m1_8001", y1, 32'h00008001);
    @(posedge clk); a = 16'hFFFF; @(negedge clk);
    check("m1_ffff", y1, 32'h0000FFFF);
    check("m3_ffff", y3, 32'hFFFFFFFC);
    @(posedge clk); a = 16'hABCD; @(negedge clk);
    check("m2_abcd", y2, 32'hABCD0000);
    @(posedge clk); a = 16'h0001; @(negedge clk);
    check("m3_0001", y3, 32'h00000004);
    check("m2_0001", y2, 32'h00010000);
    @(posedge clk); a = 16'h8000; @(negedge clk);
    check("m3_8000", y3, 32'hFFFE0000);
    @(posedge clk); a = 16'h7FFF; @(negedge clk);
    check("m3_7fff", y3, 32'h0001FFFC);
    check("rst_still_y_r", yr0, 32'h0);

    // Registered path: release reset with a load pending
    rst = 1'b1; en = 1'b1; a = 16'h8000;
    @(posedge clk); @(negedge clk);
    check("load_y_r", yr0, 32'hFFFF8000);
    check("load_valid", {31'b0, v0}, 32'h1);
    check("load_m3_y_r", yr3, 32'hFFFE0000);
    $display("load: a=8000 y_r=%h valid=%b", yr0, v0);

    en = 1'b0; a = 16'h1234;
    @(posedge clk); @(negedge clk);
    check("hold_y_r", yr0, 32'hFFFF8000);
    check("hold_valid", {31'b0, v0}, 32'h1);
    check("hold_comb_y", y0, 32'h00001234);

    en = 1'b1; a = 16'h0042;
    @(posedge clk); @(negedge clk);
    check("reload_y_r", yr0, 32'h00000042);
    check("reload_m2_y_r", yr2, 32'h00420000);

    // Mid-stream reset wins over en
    rst = 1'b0; en = 1'b1; a = 16'h7FFF;
    @(posedge clk); @(negedge clk);
    check("midrst_y_r", yr0, 32'h0);
    check("midrst_valid", {31'b0, v0}, 32'h0);

    rst = 1'b1; en = 1'b1; a = 16'hFFFF;
    @(posedge clk); @(negedge clk);
    check("post_rst_y_r", yr0, 32'hFFFFFFFF);
    check("post_rst_valid", {31'b0, v0}, 32'h1);
    check("post_rst_m1_y_r", yr1, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
